// File: rtl/reg_file_rename_pkg.sv
// rtl/reg_file_rename_pkg.sv - shared widths and constants for the rename register file
package reg_file_rename_pkg;

  localparam int REG_NUM    = 32;
  localparam int REG_WIDTH  = 5;
  localparam int DATA_WIDTH = 32;
  localparam int ROB_WIDTH  = 4;

  // ROB id 0 is never allocated, so a zero tag means "no producer"
  localparam logic [ROB_WIDTH-1:0] NO_TAG = '0;

endpackage

// File: rtl/reg_file_rename_rf_read_port.sv
// rtl/reg_file_rename_rf_read_port.sv - one combinational source-operand read with commit bypass
module rf_read_port
  import reg_file_rename_pkg::*;
(
  input  logic [REG_WIDTH-1:0]  rs_i,
  input  logic                  busy_i,
  input  logic [ROB_WIDTH-1:0]  tag_i,
  input  logic [DATA_WIDTH-1:0] val_i,
  input  logic                  commit_en_i,
  input  logic [REG_WIDTH-1:0]  commit_dest_i,
  input  logic [DATA_WIDTH-1:0] commit_val_i,
  input  logic [ROB_WIDTH-1:0]  commit_rob_i,
  output logic                  busy_o,
  output logic [ROB_WIDTH-1:0]  rob_o,
  output logic [DATA_WIDTH-1:0] val_o
);

  logic bypass;

  assign bypass = commit_en_i && (commit_dest_i == rs_i) && busy_i && (tag_i == commit_rob_i);

  always_comb begin
    busy_o = 1'b0;
    rob_o  = NO_TAG;
    val_o  = '0;
    if (rs_i != '0) begin
      if (bypass) begin
        val_o = commit_val_i;
      end else begin
        busy_o = busy_i;
        rob_o  = busy_i ? tag_i : NO_TAG;
        val_o  = val_i;
      end
    end
  end

endmodule

// File: rtl/reg_file_rename.sv
// rtl/reg_file_rename.sv - architectural register file with per-register ROB rename tags
module reg_file_rename
  import reg_file_rename_pkg::*;
(
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  rdy_in,
  input  logic [REG_WIDTH-1:0]  rs1_dp_in,
  input  logic [REG_WIDTH-1:0]  rs2_dp_in,
  output logic                  rs1_busy_dp_out,
  output logic [ROB_WIDTH-1:0]  rs1_rob_dp_out,
  output logic [DATA_WIDTH-1:0] rs1_val_dp_out,
  output logic                  rs2_busy_dp_out,
  output logic [ROB_WIDTH-1:0]  rs2_rob_dp_out,
  output logic [DATA_WIDTH-1:0] rs2_val_dp_out,
  input  logic                  rename_en_dp_in,
  input  logic [REG_WIDTH-1:0]  rename_rd_dp_in,
  input  logic [ROB_WIDTH-1:0]  rename_rob_dp_in,
  input  logic                  rdy_commit_rob_in,
  input  logic [REG_WIDTH-1:0]  dest_rob_in,
  input  logic [DATA_WIDTH-1:0] value_rob_in,
  input  logic [ROB_WIDTH-1:0]  rob_id_rob_in,
  input  logic                  refresh_cdb_in
);

  logic [DATA_WIDTH-1:0] value_q [REG_NUM];
  logic [DATA_WIDTH-1:0] value_d [REG_NUM];
  logic                  busy_q  [REG_NUM];
  logic                  busy_d  [REG_NUM];
  logic [ROB_WIDTH-1:0]  tag_q   [REG_NUM];
  logic [ROB_WIDTH-1:0]  tag_d   [REG_NUM];

  logic do_rename;
  logic do_commit;

  assign do_rename = rename_en_dp_in && !refresh_cdb_in && (rename_rd_dp_in != '0);
  assign do_commit = rdy_commit_rob_in && (dest_rob_in != '0);

  always_comb begin
    value_d = value_q;
    busy_d  = busy_q;
    tag_d   = tag_q;
    if (rdy_in) begin
      if (do_commit) begin
        value_d[dest_rob_in] = value_rob_in;
        // a newer rename of the same register keeps it busy under the new tag
        if ((tag_q[dest_rob_in] == rob_id_rob_in) &&
            !(do_rename && (rename_rd_dp_in == dest_rob_in))) begin
          busy_d[dest_rob_in] = 1'b0;
          tag_d[dest_rob_in]  = NO_TAG;
        end
      end
      if (refresh_cdb_in) begin
        for (int i = 0; i < REG_NUM; i++) begin
          busy_d[i] = 1'b0;
          tag_d[i]  = NO_TAG;
        end
      end else if (do_rename) begin
        busy_d[rename_rd_dp_in] = 1'b1;
        tag_d[rename_rd_dp_in]  = rename_rob_dp_in;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      for (int i = 0; i < REG_NUM; i++) begin
        value_q[i] <= '0;
        busy_q[i]  <= 1'b0;
        tag_q[i]   <= NO_TAG;
      end
    end else begin
      value_q <= value_d;
      busy_q  <= busy_d;
      tag_q   <= tag_d;
    end
  end

  rf_read_port u_rs1 (
    .rs_i          (rs1_dp_in),
    .busy_i        (busy_q[rs1_dp_in]),
    .tag_i         (tag_q[rs1_dp_in]),
    .val_i         (value_q[rs1_dp_in]),
    .commit_en_i   (rdy_commit_rob_in),
    .commit_dest_i (dest_rob_in),
    .commit_val_i  (value_rob_in),
    .commit_rob_i  (rob_id_rob_in),
    .busy_o        (rs1_busy_dp_out),
    .rob_o         (rs1_rob_dp_out),
    .val_o         (rs1_val_dp_out)
  );

  rf_read_port u_rs2 (
    .rs_i          (rs2_dp_in),
    .busy_i        (busy_q[rs2_dp_in]),
    .tag_i         (tag_q[rs2_dp_in]),
    .val_i         (value_q[rs2_dp_in]),
    .commit_en_i   (rdy_commit_rob_in),
    .commit_dest_i (dest_rob_in),
    .commit_val_i  (value_rob_in),
    .commit_rob_i  (rob_id_rob_in),
    .busy_o        (rs2_busy_dp_out),
    .rob_o         (rs2_rob_dp_out),
    .val_o         (rs2_val_dp_out)
  );

endmodule

// File: tb/tb_reg_file_rename.sv
// tb/tb_reg_file_rename.sv - directed and randomized checks of reg_file_rename against a reference model
module tb_reg_file_rename;

  logic        clk = 1'b0;
  logic        rst_n, rdy, ren, cen, refresh;
  logic [4:0]  rs1, rs2, rrd, cdest;
  logic [3:0]  rrob, cid;
  logic [31:0] cval;
  logic        r1_busy, r2_busy;
  logic [3:0]  r1_rob, r2_rob;
  logic [31:0] r1_val, r2_val;

  int total = 0;
  int bad   = 0;

  // reference state: committed value and pending producer (0 = none) per register
  logic [31:0] m_val  [32];
  logic [3:0]  m_prod [32];

  always #5 clk = ~clk;

  reg_file_rename dut (
    .clk_in            (clk),
    .rst_in            (rst_n),
    .rdy_in            (rdy),
    .rs1_dp_in         (rs1),
    .rs2_dp_in         (rs2),
    .rs1_busy_dp_out   (r1_busy),
    .rs1_rob_dp_out    (r1_rob),
    .rs1_val_dp_out    (r1_val),
    .rs2_busy_dp_out   (r2_busy),
    .rs2_rob_dp_out    (r2_rob),
    .rs2_val_dp_out    (r2_val),
    .rename_en_dp_in   (ren),
    .rename_rd_dp_in   (rrd),
    .rename_rob_dp_in  (rrob),
    .rdy_commit_rob_in (cen),
    .dest_rob_in       (cdest),
    .value_rob_in      (cval),
    .rob_id_rob_in     (cid),
    .refresh_cdb_in    (refresh)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    ren = 1'b0; cen = 1'b0; refresh = 1'b0;
    rrd = '0; rrob = '0; cdest = '0; cval = '0; cid = '0;
  endtask

  // what the Dispatcher should see for register r given the current inputs
  task automatic expect_read(input logic [4:0] r, output logic b, output logic [3:0] id,
                             output logic [31:0] v);
    b = 1'b0; id = 4'd0; v = 32'd0;
    if (r != 0) begin
      if (m_prod[r] != 0 && cen && cdest == r && m_prod[r] == cid) begin
        v = cval;
      end else begin
        b  = (m_prod[r] != 0);
        id = m_prod[r];
        v  = m_val[r];
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic b; logic [3:0] id; logic [31:0] v;
    #1;
    expect_read(rs1, b, id, v);
    chk({tag, ".rs1_busy"}, 32'(r1_busy), 32'(b));
    chk({tag, ".rs1_rob"},  32'(r1_rob),  32'(id));
    chk({tag, ".rs1_val"},  r1_val,       v);
    expect_read(rs2, b, id, v);
    chk({tag, ".rs2_busy"}, 32'(r2_busy), 32'(b));
    chk({tag, ".rs2_rob"},  32'(r2_rob),  32'(id));
    chk({tag, ".rs2_val"},  r2_val,       v);
  endtask

  // advance one clock, applying the architectural rules to the model
  task automatic tick();
    logic [31:0] nv [32];
    logic [3:0]  np [32];
    nv = m_val; np = m_prod;
    if (!rst_n) begin
      foreach (nv[i]) begin nv[i] = 0; np[i] = 0; end
    end else if (rdy) begin
      if (cen && cdest != 0) begin
        nv[cdest] = cval;
        if (m_prod[cdest] == cid) np[cdest] = 0;
      end
      if (refresh) begin
        foreach (np[i]) np[i] = 0;
      end else if (ren && rrd != 0) begin
        np[rrd] = rrob;
      end
    end
    @(posedge clk);
    m_val = nv; m_prod = np;
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; rdy = 1'b1; rs1 = '0; rs2 = '0;
    idle();
    foreach (m_val[i]) begin m_val[i] = 32'hX; m_prod[i] = 4'hX; end
    @(negedge clk);

    // 1: reset
    tick();
    rst_n = 1'b1; rs1 = 5'd5; rs2 = 5'd0;
    #1;
    chk("t1.busy", 32'(r1_busy), 0);
    chk("t1.rob",  32'(r1_rob),  0);
    chk("t1.val",  r1_val,       0);

    // 2: rename, bypass, commit
    ren = 1'b1; rrd = 5'd3; rrob = 4'd4;
    tick();
    idle(); rs1 = 5'd3;
    #1;
    chk("t2.busy", 32'(r1_busy), 1);
    chk("t2.rob",  32'(r1_rob),  4);
    cen = 1'b1; cdest = 5'd3; cval = 32'hDEAD; cid = 4'd4;
    #1;
    chk("t2.byp_busy", 32'(r1_busy), 0);
    chk("t2.byp_val",  r1_val,       32'hDEAD);
    tick();
    idle();
    #1;
    chk("t2.st_val",  r1_val,       32'hDEAD);
    chk("t2.st_busy", 32'(r1_busy), 0);

    // 3: stale commit leaves newer tag
    ren = 1'b1; rrd = 5'd3; rrob = 4'd4; tick();
    rrob = 4'd7; tick();
    idle(); cen = 1'b1; cdest = 5'd3; cval = 32'h11; cid = 4'd4;
    #1;
    chk("t3.nobyp_rob", 32'(r1_rob), 7);
    tick();
    idle();
    #1;
    chk("t3.val",  r1_val,       32'h11);
    chk("t3.busy", 32'(r1_busy), 1);
    chk("t3.rob",  32'(r1_rob),  7);

    // 4: commit and rename same register same cycle
    ren = 1'b1; rrd = 5'd6; rrob = 4'd2; tick();
    cen = 1'b1; cdest = 5'd6; cval = 32'h66; cid = 4'd2; rrob = 4'd9;
    tick();
    idle(); rs1 = 5'd6;
    #1;
    chk("t4.busy", 32'(r1_busy), 1);
    chk("t4.rob",  32'(r1_rob),  9);
    chk("t4.val",  r1_val,       32'h66);

    // 5: refresh with commit and ignored rename
    ren = 1'b1; rrd = 5'd2; rrob = 4'd1; tick();
    rrd = 5'd8; rrob = 4'd3; tick();
    refresh = 1'b1; cen = 1'b1; cdest = 5'd1; cval = 32'h104; cid = 4'd5;
    rrd = 5'd4; rrob = 4'd5;
    tick();
    idle(); rs1 = 5'd2; rs2 = 5'd8;
    #1;
    chk("t5.x2_busy", 32'(r1_busy), 0);
    chk("t5.x8_busy", 32'(r2_busy), 0);
    rs1 = 5'd1; rs2 = 5'd4;
    #1;
    chk("t5.x1_val",  r1_val,       32'h104);
    chk("t5.x4_busy", 32'(r2_busy), 0);

    // 6: x0 writes discarded, rdy low holds state
    ren = 1'b1; rrd = 5'd0; rrob = 4'd3;
    cen = 1'b1; cdest = 5'd0; cval = 32'hFF; cid = 4'd3;
    tick();
    idle(); rs1 = 5'd0;
    #1;
    chk("t6.x0_busy", 32'(r1_busy), 0);
    chk("t6.x0_rob",  32'(r1_rob),  0);
    chk("t6.x0_val",  r1_val,       0);
    rdy = 1'b0; ren = 1'b1; rrd = 5'd7; rrob = 4'd1;
    cen = 1'b1; cdest = 5'd7; cval = 32'h77; cid = 4'd1;
    tick();
    rdy = 1'b1; idle(); rs1 = 5'd7;
    #1;
    chk("t6.x7_busy", 32'(r1_busy), 0);
    chk("t6.x7_val",  r1_val,       0);

    // randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst_n   = ($urandom_range(0, 99) != 0);
      rdy     = ($urandom_range(0, 9) != 0);
      refresh = ($urandom_range(0, 19) == 0);
      ren     = $urandom_range(0, 1);
      rrd     = 5'($urandom_range(0, 7));
      rrob    = 4'($urandom_range(1, 15));
      cen     = $urandom_range(0, 1);
      cdest   = 5'($urandom_range(0, 7));
      cval    = $urandom;
      cid     = ($urandom_range(0, 1) != 0) ? m_prod[cdest] : 4'($urandom_range(1, 15));
      rs1     = ($urandom_range(0, 1) != 0) ? cdest : 5'($urandom_range(0, 7));
      rs2     = 5'($urandom_range(0, 7));
      check_model("rnd");
      tick();
    end
    rst_n = 1'b1; rdy = 1'b1; idle();
    for (int r = 0; r < 8; r++) begin
      rs1 = 5'(r); rs2 = 5'(7 - r);
      check_model("final");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
